k12a_input_conditioner: RTL and testbench

//  Upstream front end for the I/O block's input pins. Synchronises and debounces the 24 raw

---
 rtl/k12a_pkg.sv | 9 +
 rtl/k12a_input_conditioner_debounce.sv | 55 +++++
 rtl/k12a_input_conditioner.sv | 98 +++++++++
 tb/tb_k12a_input_conditioner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/k12a_pkg.sv
// Shared sizing constants and types for the k12a GPIO input path.
package k12a_pkg;

    localparam int K12A_GPIO_PORTS = 3;
    localparam int K12A_GPIO_WIDTH = 8;

    typedef logic [7:0] k12a_byte_t;

endpackage

// File: rtl/k12a_input_conditioner_debounce.sv
// One GPIO bit: two-flop synchroniser followed by a tick-sampled run-length debouncer.
module k12a_debounce_bit
    import k12a_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic cpu_clock,
    input  logic reset_n,
    input  logic sample_tick,
    input  logic raw,
    output logic level
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SAMPLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       stable_q;
    logic       stable_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Any agreeing sample restarts the run, so only an unbroken run of N ticks is accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sample_tick) begin
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q < CNT_LAST) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;

endmodule

// File: rtl/k12a_input_conditioner.sv
// GPIO input front end: sample prescaler, 24 debounced pins, and sticky wake flags on port 0.
module k12a_input_conditioner
    import k12a_pkg::*;
#(
    parameter int PRESCALE_DIV     = 16,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int WAKE_ON_FALL     = 0
) (
    input  logic       cpu_clock,
    input  logic       reset_n,
    input  logic [7:0] pin_in0,
    input  logic [7:0] pin_in1,
    input  logic [7:0] pin_in2,
    input  logic       wake_clear,
    output logic [7:0] gpio_in0,
    output logic [7:0] gpio_in1,
    output logic [7:0] gpio_in2,
    output logic [7:0] wake_sources,
    output logic       sample_tick
);

    localparam int              PW       = $clog2(PRESCALE_DIV) + 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE_DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick_q;
    logic          tick_d;

    k12a_byte_t pins   [K12A_GPIO_PORTS];
    k12a_byte_t levels [K12A_GPIO_PORTS];

    k12a_byte_t prev0_q;
    k12a_byte_t prev0_d;
    k12a_byte_t wake_q;
    k12a_byte_t wake_d;
    k12a_byte_t rise;
    k12a_byte_t fall;

    assign pins[0] = pin_in0;
    assign pins[1] = pin_in1;
    assign pins[2] = pin_in2;

    // The tick flop is loaded from the next count so it is high exactly while pre_q == PRE_LAST.
    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        tick_d = (pre_d == PRE_LAST);
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    for (genvar p = 0; p < K12A_GPIO_PORTS; p++) begin : g_port
        for (genvar b = 0; b < K12A_GPIO_WIDTH; b++) begin : g_bit
            k12a_debounce_bit #(
                .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
            ) u_db (
                .cpu_clock  (cpu_clock),
                .reset_n    (reset_n),
                .sample_tick(tick_q),
                .raw        (pins[p][b]),
                .level      (levels[p][b])
            );
        end
    end

    // Set has priority over clear so an edge landing with wake_clear is never lost.
    always_comb begin
        prev0_d = levels[0];
        rise    = levels[0] & ~prev0_q;
        fall    = ~levels[0] & prev0_q;
        wake_d  = (wake_clear ? '0 : wake_q) | ((WAKE_ON_FALL != 0) ? fall : rise);
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            prev0_q <= '0;
            wake_q  <= '0;
        end else begin
            prev0_q <= prev0_d;
            wake_q  <= wake_d;
        end
    end

    assign gpio_in0     = levels[0];
    assign gpio_in1     = levels[1];
    assign gpio_in2     = levels[2];
    assign wake_sources = wake_q;
    assign sample_tick  = tick_q;

endmodule

// File: tb/tb_k12a_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output events; a negedge monitor matches them.
module tb_k12a_input_conditioner;

    typedef struct {
        string      name;
        logic [7:0] g0;
        logic [7:0] g1;
        logic [7:0] g2;
        logic [7:0] wk;
        int         lo;
        int         hi;
        bit         rel1;
    } ev_t;

    typedef struct {
        string      name;
        logic [7:0] g0;
        logic [7:0] g1;
        logic [7:0] g2;
        logic [7:0] wk;
        bit         chk_tick;
        logic       tick;
    } snap_t;

    logic       cpu_clock = 1'b0;
    logic       reset_n;
    logic [7:0] pin_in0;
    logic [7:0] pin_in1;
    logic [7:0] pin_in2;
    logic       wake_clear;
    logic [7:0] gpio_in0;
    logic [7:0] gpio_in1;
    logic [7:0] gpio_in2;
    logic [7:0] wake_sources;
    logic       sample_tick;

    ev_t   evq[$];
    snap_t snq[$];

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  last_ev = -100;
    bit  mon_en = 1'b0;
    bit  mon_init = 1'b0;
    bit  final_req = 1'b0;
    bit  final_done = 1'b0;
    logic [31:0] prev_out;

    k12a_input_conditioner #(
        .PRESCALE_DIV    (4),
        .DEBOUNCE_SAMPLES(3),
        .WAKE_ON_FALL    (0)
    ) dut (
        .cpu_clock   (cpu_clock),
        .reset_n     (reset_n),
        .pin_in0     (pin_in0),
        .pin_in1     (pin_in1),
        .pin_in2     (pin_in2),
        .wake_clear  (wake_clear),
        .gpio_in0    (gpio_in0),
        .gpio_in1    (gpio_in1),
        .gpio_in2    (gpio_in2),
        .wake_sources(wake_sources),
        .sample_tick (sample_tick)
    );

    always #5 cpu_clock = ~cpu_clock;

    always @(posedge cpu_clock) cyc <= cyc + 1;

    always @(negedge cpu_clock) begin
        logic [31:0] cur;
        ev_t         e;
        snap_t       s;
        bit          ok;
        cur = {gpio_in0, gpio_in1, gpio_in2, wake_sources};
        while (snq.size() > 0) begin
            s  = snq.pop_front();
            ok = (cur == {s.g0, s.g1, s.g2, s.wk}) && (!s.chk_tick || sample_tick == s.tick);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s: got g0=%02h g1=%02h g2=%02h wake=%02h tick=%0b, want g0=%02h g1=%02h g2=%02h wake=%02h tick=%0b",
                         s.name, gpio_in0, gpio_in1, gpio_in2, wake_sources, sample_tick,
                         s.g0, s.g1, s.g2, s.wk, s.tick);
            end
        end
        if (mon_en) begin
            if (!mon_init) begin
                mon_init = 1'b1;
            end else if (cur != prev_out) begin
                if (evq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_change: cycle %0d got %08h, previous %08h, nothing expected",
                             cyc, cur, prev_out);
                end else begin
                    e = evq.pop_front();
                    n_cmp++;
                    if (cur != {e.g0, e.g1, e.g2, e.wk}) begin
                        n_bad++;
                        $display("FAIL %s_value: got g0=%02h g1=%02h g2=%02h wake=%02h, want g0=%02h g1=%02h g2=%02h wake=%02h",
                                 e.name, gpio_in0, gpio_in1, gpio_in2, wake_sources, e.g0, e.g1, e.g2, e.wk);
                    end
                    n_cmp++;
                    if (cyc < e.lo || cyc > e.hi || (e.rel1 && cyc != last_ev + 1)) begin
                        n_bad++;
                        $display("FAIL %s_timing: got cycle %0d (previous event %0d), want %0d..%0d%s",
                                 e.name, cyc, last_ev, e.lo, e.hi, e.rel1 ? " and previous+1" : "");
                    end
                end
                last_ev = cyc;
            end
            prev_out = cur;
            if (evq.size() > 0 && cyc > evq[0].hi) begin
                e = evq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s_timeout: no change by cycle %0d, want g0=%02h g1=%02h g2=%02h wake=%02h",
                         e.name, e.hi, e.g0, e.g1, e.g2, e.wk);
            end
        end
        if (final_req && !final_done) begin
            n_cmp++;
            if (evq.size() != 0) begin
                n_bad++;
                $display("FAIL pending_events: got %0d outstanding, want 0", evq.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge cpu_clock);
            #2;
        end
    endtask

    task automatic expect_ev(input string nm, input logic [7:0] g0, input logic [7:0] g1,
                             input logic [7:0] g2, input logic [7:0] wk,
                             input int lo, input int hi, input bit rel1);
        ev_t e;
        e.name = nm; e.g0 = g0; e.g1 = g1; e.g2 = g2; e.wk = wk;
        e.lo = lo; e.hi = hi; e.rel1 = rel1;
        evq.push_back(e);
    endtask

    task automatic expect_snap(input string nm, input logic [7:0] g0, input logic [7:0] g1,
                               input logic [7:0] g2, input logic [7:0] wk,
                               input bit chk_tick, input logic tick);
        snap_t s;
        s.name = nm; s.g0 = g0; s.g1 = g1; s.g2 = g2; s.wk = wk;
        s.chk_tick = chk_tick; s.tick = tick;
        snq.push_back(s);
    endtask

    initial begin
        int c;
        reset_n    = 1'b0;
        pin_in0    = 8'hFF;
        pin_in1    = 8'hFF;
        pin_in2    = 8'hFF;
        wake_clear = 1'b0;

        // 1. pins high through reset; all outputs stay 0, then come up together
        step(3);
        expect_snap("reset_state", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        mon_en = 1'b1;
        step(1);
        reset_n = 1'b1;
        c = cyc;
        expect_ev("release_ff", 8'hFF, 8'hFF, 8'hFF, 8'h00, c + 11, c + 14, 1'b0);
        expect_ev("wake_ff",    8'hFF, 8'hFF, 8'hFF, 8'hFF, c + 12, c + 15, 1'b1);
        step(20);

        pin_in0 = 8'h00; pin_in1 = 8'h00; pin_in2 = 8'h00;
        c = cyc;
        expect_ev("pins_low", 8'h00, 8'h00, 8'h00, 8'hFF, c + 11, c + 14, 1'b0);
        step(20);
        wake_clear = 1'b1;
        c = cyc;
        expect_ev("clear_all", 8'h00, 8'h00, 8'h00, 8'h00, c + 1, c + 1, 1'b0);
        step(1);
        wake_clear = 1'b0;
        step(10);

        // 2. single bit step on port 1
        pin_in1 = 8'h20;
        c = cyc;
        expect_ev("p1_bit5", 8'h00, 8'h20, 8'h00, 8'h00, c + 11, c + 14, 1'b0);
        step(20);

        // 3. short glitch is filtered, then a bounced step gives one transition
        pin_in2 = 8'h01;
        step(5);
        pin_in2 = 8'h00;
        step(40);
        expect_snap("glitch_hold", 8'h00, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1);
        pin_in2 = 8'h01;
        c = cyc;
        expect_ev("bounce", 8'h00, 8'h20, 8'h01, 8'h00, c + 11, c + 20, 1'b0);
        step(3);
        pin_in2 = 8'h00;
        step(3);
        pin_in2 = 8'h01;
        step(25);

        // 4. wake on rising edge of port 0 bit 3, held
        pin_in0 = 8'h08;
        c = cyc;
        expect_ev("p0_bit3",   8'h08, 8'h20, 8'h01, 8'h00, c + 11, c + 14, 1'b0);
        expect_ev("wake_bit3", 8'h08, 8'h20, 8'h01, 8'h08, c + 12, c + 15, 1'b1);
        step(25);
        expect_snap("wake_held", 8'h08, 8'h20, 8'h01, 8'h08, 1'b0, 1'b0);
        step(1);

        // 5. clear coincides with a new edge on bit 6: bit 3 clears, bit 6 survives
        pin_in0 = 8'h48;
        c = cyc;
        expect_ev("p0_bit6",      8'h48, 8'h20, 8'h01, 8'h08, c + 11, c + 14, 1'b0);
        expect_ev("wake_set_clr", 8'h48, 8'h20, 8'h01, 8'h40, c + 12, c + 15, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge cpu_clock);
            if (gpio_in0[6]) break;
        end
        wake_clear = 1'b1;
        @(negedge cpu_clock);
        wake_clear = 1'b0;
        step(10);
        wake_clear = 1'b1;
        c = cyc;
        expect_ev("clear_bit6", 8'h48, 8'h20, 8'h01, 8'h00, c + 1, c + 1, 1'b0);
        step(1);
        wake_clear = 1'b0;
        step(10);

        // 6. reset mid-debounce of port 0 bit 1; latency restarts from release
        pin_in0 = 8'h4A;
        step(10);
        reset_n = 1'b0;
        c = cyc;
        expect_ev("reset_mid", 8'h00, 8'h00, 8'h00, 8'h00, c, c, 1'b0);
        step(3);
        expect_snap("reset_mid_state", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        step(1);
        reset_n = 1'b1;
        c = cyc;
        expect_ev("release_4a", 8'h4A, 8'h20, 8'h01, 8'h00, c + 11, c + 14, 1'b0);
        expect_ev("wake_4a",    8'h4A, 8'h20, 8'h01, 8'h4A, c + 12, c + 15, 1'b1);
        step(25);

        final_req = 1'b1;
        for (int i = 0; i < 4 && !final_done; i++) @(negedge cpu_clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
